// File: rtl/malu_pkg.sv
// Shared types and decode helpers for the sequential RV32M/RV64M multiply/divide unit.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package malu_pkg;

   // funct3 encoding of the M-extension ops
   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } op_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MUL,
      ST_DIV,
      ST_FIX,
      ST_DONE
   } state_t;

   function automatic logic is_div(input op_t op);
      return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

   function automatic logic is_rem(input op_t op);
      return op inside {OP_REM, OP_REMU};
   endfunction

   // rs1 is treated as two's complement
   function automatic logic is_signed_x(input op_t op);
      return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
   endfunction

   // rs2 is treated as two's complement
   function automatic logic is_signed_y(input op_t op);
      return op inside {OP_MULH, OP_DIV, OP_REM};
   endfunction

endpackage

// File: rtl/malu_seq_div_iter.sv
// Unsigned radix-2 restoring divider core: one quotient bit per cycle.
// Latency: XLEN cycles after the start edge; done is high in the cycle whose edge retires the last bit.
// Backpressure: none; abort drops the operation, a new start reloads it.
module div_iter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic            done,
   output logic [XLEN-1:0] quo,
   output logic [XLEN-1:0] rem
);

   localparam int CW = $clog2(XLEN);

   logic            running;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] dvsr;
   logic [XLEN:0]   trial;
   logic [XLEN:0]   diff;

   // shift the next dividend bit into the partial remainder and try subtracting the divisor
   always_comb begin
      trial = {rem, quo[XLEN-1]};
      diff  = trial - {1'b0, dvsr};
   end

   assign done = running && (cnt == CW'(XLEN - 1));

   // quotient bits are shifted into quo as the dividend bits are shifted out of it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         running <= 1'b0;
         cnt     <= '0;
         dvsr    <= '0;
         quo     <= '0;
         rem     <= '0;
      end else if (abort) begin
         running <= 1'b0;
         cnt     <= '0;
      end else if (start) begin
         running <= 1'b1;
         cnt     <= '0;
         dvsr    <= divisor;
         quo     <= dividend;
         rem     <= '0;
      end else if (running) begin
         if (diff[XLEN]) begin
            rem <= trial[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b0};
         end else begin
            rem <= diff[XLEN-1:0];
            quo <= {quo[XLEN-2:0], 1'b1};
         end
         cnt <= cnt + 1'b1;
         if (done) begin
            running <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/malu_seq.sv
// Multi-cycle M-extension unit: pipelined-latency multiply, iterative restoring divide with early-out.
// Latency: multiply MUL_STAGES, normal divide XLEN+1, divide special cases 1 cycle after accept.
// Backpressure: o_ready only in IDLE; result held in DONE until i_ready; i_kill aborts from any state.
module malu_seq
   import malu_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int MUL_STAGES = 2
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [2:0]      i_op,
   input  logic [XLEN-1:0] i_x,
   input  logic [XLEN-1:0] i_y,
   input  logic            i_kill,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_res,
   output logic            o_busy
);

   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_t          state;
   op_t             op_q;
   logic [XLEN-1:0] x_q;
   logic [XLEN-1:0] y_q;
   logic [2:0]      cnt;

   op_t             op_in;
   logic            accept;
   logic [XLEN-1:0] x_mag;
   logic [XLEN-1:0] y_mag;

   logic            div_start;
   logic            div_abort;
   logic            div_done;
   logic [XLEN-1:0] div_quo;
   logic [XLEN-1:0] div_rem;

   logic            div_special;
   logic [XLEN-1:0] special_res;
   logic            quo_neg;
   logic            rem_neg;
   logic [XLEN-1:0] fix_res;

   logic signed [2*XLEN+1:0] mx;
   logic signed [2*XLEN+1:0] my;
   logic signed [2*XLEN+1:0] prod;
   logic [XLEN-1:0]          mul_res;
   logic                     unused_prod_top;

   assign o_ready = (state == ST_IDLE);
   assign o_busy  = (state != ST_IDLE);
   assign op_in   = op_t'(i_op);
   assign accept  = i_valid && o_ready && !i_kill;

   // operand magnitudes feed the divider straight from the request so it starts on the accept edge
   always_comb begin
      x_mag = (is_signed_x(op_in) && i_x[XLEN-1]) ? -i_x : i_x;
      y_mag = (is_signed_y(op_in) && i_y[XLEN-1]) ? -i_y : i_y;
   end

   // y==0 and signed overflow bypass the iteration; detected in the first DIV cycle on held operands
   always_comb begin
      special_res = '0;
      div_special = 1'b0;
      if (y_q == '0) begin
         div_special = 1'b1;
         special_res = is_rem(op_q) ? x_q : '1;
      end else if (is_signed_y(op_q) && (x_q == MOST_NEG) && (y_q == '1)) begin
         div_special = 1'b1;
         special_res = is_rem(op_q) ? '0 : x_q;
      end
   end

   assign div_start = accept && is_div(op_in);
   assign div_abort = i_kill || ((state == ST_DIV) && (cnt == 3'd0) && div_special);

   div_iter #(
      .XLEN (XLEN)
   ) u_div (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .start    (div_start),
      .abort    (div_abort),
      .dividend (x_mag),
      .divisor  (y_mag),
      .done     (div_done),
      .quo      (div_quo),
      .rem      (div_rem)
   );

   // restore signs: quotient negative when signs differ, remainder takes the sign of x
   always_comb begin
      quo_neg = is_signed_x(op_q) && (x_q[XLEN-1] ^ y_q[XLEN-1]);
      rem_neg = is_signed_x(op_q) && x_q[XLEN-1];
      if (is_rem(op_q)) begin
         fix_res = rem_neg ? -div_rem : div_rem;
      end else begin
         fix_res = quo_neg ? -div_quo : div_quo;
      end
   end

   // one wide signed product covers all four multiplies; the MUL dwell gives it MUL_STAGES cycles to settle
   always_comb begin
      mx      = {{(XLEN+2){is_signed_x(op_q) & x_q[XLEN-1]}}, x_q};
      my      = {{(XLEN+2){is_signed_y(op_q) & y_q[XLEN-1]}}, y_q};
      prod    = mx * my;
      mul_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
   end

   assign unused_prod_top = ^prod[2*XLEN+1:2*XLEN];

   // control FSM with registered result and valid; kill wins over accept and over i_ready
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= ST_IDLE;
         op_q    <= OP_MUL;
         x_q     <= '0;
         y_q     <= '0;
         cnt     <= '0;
         o_valid <= 1'b0;
         o_res   <= '0;
      end else if (i_kill) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         o_valid <= 1'b0;
         o_res   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_valid) begin
                  op_q  <= op_in;
                  x_q   <= i_x;
                  y_q   <= i_y;
                  cnt   <= '0;
                  state <= is_div(op_in) ? ST_DIV : ST_MUL;
               end
            end
            ST_MUL: begin
               if (cnt == 3'(MUL_STAGES - 1)) begin
                  o_res   <= mul_res;
                  o_valid <= 1'b1;
                  state   <= ST_DONE;
               end else begin
                  cnt <= cnt + 3'd1;
               end
            end
            ST_DIV: begin
               cnt <= 3'd1;
               if ((cnt == 3'd0) && div_special) begin
                  o_res   <= special_res;
                  o_valid <= 1'b1;
                  state   <= ST_DONE;
               end else if (div_done) begin
                  state <= ST_FIX;
               end
            end
            ST_FIX: begin
               o_res   <= fix_res;
               o_valid <= 1'b1;
               state   <= ST_DONE;
            end
            ST_DONE: begin
               if (i_ready) begin
                  o_valid <= 1'b0;
                  state   <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_malu_seq.sv
// Directed bench for malu_seq: 32-bit/2-stage and 64-bit/4-stage instances.
// Latency: each check counts cycles from the accept edge to o_valid.
// Backpressure: exercises result hold, kill and mid-operation reset.
module tb_malu_seq;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        req_vld, req_rdy, kill, rsp_vld, rsp_rdy, busy;
   logic [2:0]  op;
   logic [31:0] x, y, res;

   logic        req_vld_w, req_rdy_w, kill_w, rsp_vld_w, rsp_rdy_w, busy_w;
   logic [2:0]  op_w;
   logic [63:0] x_w, y_w, res_w;

   int n_pass  = 0;
   int n_total = 0;

   malu_seq #(.XLEN(32), .MUL_STAGES(2)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(req_vld), .o_ready(req_rdy),
      .i_op(op), .i_x(x), .i_y(y), .i_kill(kill), .o_valid(rsp_vld),
      .i_ready(rsp_rdy), .o_res(res), .o_busy(busy)
   );

   malu_seq #(.XLEN(64), .MUL_STAGES(4)) dut_w (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(req_vld_w), .o_ready(req_rdy_w),
      .i_op(op_w), .i_x(x_w), .i_y(y_w), .i_kill(kill_w), .o_valid(rsp_vld_w),
      .i_ready(rsp_rdy_w), .o_res(res_w), .o_busy(busy_w)
   );

   // present one request for the accept edge, then scramble the inputs; returns #1 after that edge
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      req_vld = 1'b1; op = o; x = a; y = b;
      @(posedge clk); #1;
      req_vld = 1'b0; op = ~o; x = ~a; y = 32'h5a5a_5a5a;
   endtask

   // cycles after the accept edge until o_valid, -1 if it never comes
   task automatic wait_vld(output int lat);
      lat = -1;
      for (int k = 1; k <= 80; k++) begin
         @(posedge clk); #1;
         if (rsp_vld === 1'b1) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic pop();
      rsp_rdy = 1'b1;
      @(posedge clk); #1;
      rsp_rdy = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      n_total++;
      if (busy !== 1'b0 || rsp_vld !== 1'b0 || res !== 32'h0) $display("FAIL reset_hold busy=%b vld=%b res=%h want 0 0 0", busy, rsp_vld, res);
      else n_pass++;
      #20;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      n_total++;
      if (req_rdy !== 1'b1 || rsp_vld !== 1'b0 || res !== 32'h0 || busy !== 1'b0)
         $display("FAIL reset_release rdy=%b vld=%b res=%h busy=%b want 1 0 0 0", req_rdy, rsp_vld, res, busy);
      else n_pass++;
   endtask

   task automatic test_mul();
      logic [2:0]  t_op[4] = '{3'b000, 3'b011, 3'b001, 3'b010};
      logic [31:0] t_x[4]  = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
      logic [31:0] t_y[4]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
      logic [31:0] t_e[4]  = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h4000_0000, 32'hFFFF_FFFF};
      int lat;
      for (int i = 0; i < 4; i++) begin
         issue(t_op[i], t_x[i], t_y[i]);
         wait_vld(lat);
         n_total++;
         if (lat !== 2) $display("FAIL mul_lat[%0d] got %0d want 2", i, lat);
         else n_pass++;
         n_total++;
         if (res !== t_e[i]) $display("FAIL mul_res[%0d] got %h want %h", i, res, t_e[i]);
         else n_pass++;
         pop();
         n_total++;
         if (rsp_vld !== 1'b0 || req_rdy !== 1'b1) $display("FAIL mul_pop[%0d] vld=%b rdy=%b want 0 1", i, rsp_vld, req_rdy);
         else n_pass++;
      end
   endtask

   task automatic test_div();
      logic [2:0]  t_op[8] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110, 3'b101, 3'b111};
      logic [31:0] t_x[8]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                               32'd7, 32'd7, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] t_y[8]  = '{32'd2, 32'd2, 32'd7, 32'd7,
                               32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] t_e[8]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                               32'hFFFF_FFFD, 32'd1, 32'd0, 32'h8000_0000};
      int lat;
      for (int i = 0; i < 8; i++) begin
         issue(t_op[i], t_x[i], t_y[i]);
         wait_vld(lat);
         n_total++;
         if (lat !== 33) $display("FAIL div_lat[%0d] got %0d want 33", i, lat);
         else n_pass++;
         n_total++;
         if (res !== t_e[i]) $display("FAIL div_res[%0d] got %h want %h", i, res, t_e[i]);
         else n_pass++;
         pop();
      end
   endtask

   task automatic test_special();
      logic [2:0]  t_op[6] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110};
      logic [31:0] t_x[6]  = '{32'd5, 32'd5, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] t_y[6]  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] t_e[6]  = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
      int lat;
      for (int i = 0; i < 6; i++) begin
         issue(t_op[i], t_x[i], t_y[i]);
         wait_vld(lat);
         n_total++;
         if (lat !== 1) $display("FAIL spc_lat[%0d] got %0d want 1", i, lat);
         else n_pass++;
         n_total++;
         if (res !== t_e[i]) $display("FAIL spc_res[%0d] got %h want %h", i, res, t_e[i]);
         else n_pass++;
         pop();
      end
   endtask

   task automatic test_hold();
      int lat;
      issue(3'b101, 32'd100, 32'd7);
      wait_vld(lat);
      n_total++;
      if (lat !== 33) $display("FAIL hold_lat got %0d want 33", lat);
      else n_pass++;
      // offer a new request while the result is held; it must not be taken
      req_vld = 1'b1; op = 3'b000; x = 32'd3; y = 32'd3;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_total++;
         if (res !== 32'd14 || rsp_vld !== 1'b1 || req_rdy !== 1'b0)
            $display("FAIL hold[%0d] res=%h vld=%b rdy=%b want 0000000e 1 0", i, res, rsp_vld, req_rdy);
         else n_pass++;
      end
      pop();
      req_vld = 1'b0;
      n_total++;
      if (busy !== 1'b0 || rsp_vld !== 1'b0) $display("FAIL hold_no_b2b busy=%b vld=%b want 0 0", busy, rsp_vld);
      else n_pass++;
   endtask

   task automatic test_kill();
      int lat;
      bit seen = 1'b0;
      issue(3'b100, 32'hFFFF_FFF9, 32'd2);
      repeat (8) begin
         @(posedge clk); #1;
      end
      kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      n_total++;
      if (busy !== 1'b0 || rsp_vld !== 1'b0) $display("FAIL kill_idle busy=%b vld=%b want 0 0", busy, rsp_vld);
      else n_pass++;
      @(posedge clk); #1;
      n_total++;
      if (req_rdy !== 1'b1) $display("FAIL kill_ready got %b want 1", req_rdy);
      else n_pass++;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (rsp_vld === 1'b1) seen = 1'b1;
      end
      n_total++;
      if (seen !== 1'b0) $display("FAIL kill_no_result saw o_valid=%b want 0", seen);
      else n_pass++;
      // kill beats accept
      req_vld = 1'b1; op = 3'b000; x = 32'd2; y = 32'd3; kill = 1'b1;
      @(posedge clk); #1;
      req_vld = 1'b0; kill = 1'b0;
      n_total++;
      if (busy !== 1'b0) $display("FAIL kill_vs_accept busy=%b want 0", busy);
      else n_pass++;
      // divider must restart cleanly after an abort
      issue(3'b101, 32'd100, 32'd7);
      wait_vld(lat);
      n_total++;
      if (lat !== 33 || res !== 32'd14) $display("FAIL kill_recover lat=%0d res=%h want 33 0000000e", lat, res);
      else n_pass++;
      pop();
   endtask

   task automatic test_reset_mid();
      issue(3'b000, 32'd7, 32'hFFFF_FFFD);
      n_total++;
      if (busy !== 1'b1) $display("FAIL rst_mid_busy got %b want 1", busy);
      else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_total++;
      if (busy !== 1'b0 || rsp_vld !== 1'b0 || res !== 32'h0 || req_rdy !== 1'b1)
         $display("FAIL rst_mid busy=%b vld=%b res=%h rdy=%b want 0 0 0 1", busy, rsp_vld, res, req_rdy);
      else n_pass++;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_xlen64();
      logic [2:0]  t_op[3] = '{3'b000, 3'b100, 3'b101};
      logic [63:0] t_x[3]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd1000};
      logic [63:0] t_y[3]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd10};
      logic [63:0] t_e[3]  = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd100};
      int          t_l[3]  = '{4, 1, 65};
      int lat;
      for (int i = 0; i < 3; i++) begin
         req_vld_w = 1'b1; op_w = t_op[i]; x_w = t_x[i]; y_w = t_y[i];
         @(posedge clk); #1;
         req_vld_w = 1'b0; x_w = 64'h1234; y_w = 64'h5678;
         lat = -1;
         for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (rsp_vld_w === 1'b1) begin
               lat = k;
               break;
            end
         end
         n_total++;
         if (lat !== t_l[i]) $display("FAIL x64_lat[%0d] got %0d want %0d", i, lat, t_l[i]);
         else n_pass++;
         n_total++;
         if (res_w !== t_e[i]) $display("FAIL x64_res[%0d] got %h want %h", i, res_w, t_e[i]);
         else n_pass++;
         rsp_rdy_w = 1'b1;
         @(posedge clk); #1;
         rsp_rdy_w = 1'b0;
      end
   endtask

   initial begin
      req_vld = 1'b0; kill = 1'b0; rsp_rdy = 1'b0; op = 3'b0; x = '0; y = '0;
      req_vld_w = 1'b0; kill_w = 1'b0; rsp_rdy_w = 1'b0; op_w = 3'b0; x_w = '0; y_w = '0;
      test_reset();
      test_mul();
      test_div();
      test_special();
      test_hold();
      test_kill();
      test_reset_mid();
      test_xlen64();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
